scale_ctrl: RTL and testbench

- Frame-level sequencer for the integer nearest-neighbour zoom path. Walks the source image in the pixel ROM, fetches each pixel, and issues FxF replicated writes into the VGA frame-buffer RAM.
- Handles ROM read latency and RAM write back-pressure.
- Sits between the top-level control (start/zoom select) and the ROM/RAM ports; one full frame is processed per start command.

---
 rtl/scale_ctrl.sv | 171 +++++++++++++++++
 tb/tb_scale_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/scale_ctrl.sv
// rtl/scale_ctrl.sv - nearest-neighbour zoom sequencer: ROM pixel walk to FxF replicated RAM writes
// Optional abort/aborted ports enabled by SCALE_CTRL_ABORT_EN.
module scale_ctrl #(
  parameter int SRC_W      = 160,
  parameter int SRC_H      = 120,
  parameter int SRC_ADDR_W = 15,
  parameter int DST_ADDR_W = 19,
  parameter int ROM_LAT    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [1:0]            zoom,
  output logic [SRC_ADDR_W-1:0] rom_addr,
  input  logic [7:0]            rom_data,
  output logic                  ram_we,
  input  logic                  ram_ready,
  output logic [DST_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  busy,
  output logic                  done
`ifdef SCALE_CTRL_ABORT_EN
  ,
  input  logic                  abort,
  output logic                  aborted
`endif
);

  localparam int LW = (SRC_H > 1) ? $clog2(SRC_H) : 1;
  localparam int CW = (SRC_W > 1) ? $clog2(SRC_W) : 1;
  localparam int WW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [1:0]      k;
  logic [LW-1:0]   linha;
  logic [CW-1:0]   coluna;
  logic [1:0]      di, dj;
  logic [WW-1:0]   wcnt;
  logic [7:0]      pix;

  logic [2:0]      f;
  logic [1:0]      fmax;
  logic            beat, blk_end, last_px, wait_last, kill;
  logic [DST_ADDR_W-1:0] dw, row_d, col_d, addr_calc;

  assign f         = 3'd1 << k;
  assign fmax      = 2'(f - 3'd1);
  assign beat      = (state == S_WRITE) && ram_ready;
  assign blk_end   = beat && (di == fmax) && (dj == fmax);
  assign last_px   = (linha == LW'(SRC_H - 1)) && (coluna == CW'(SRC_W - 1));
  assign wait_last = (wcnt == WW'(ROM_LAT - 1));

`ifdef SCALE_CTRL_ABORT_EN
  assign kill = abort && (state != S_IDLE);
`else
  assign kill = 1'b0;
`endif

  // Destination address built at full RAM width so the zoomed row stride never wraps early.
  assign dw        = DST_ADDR_W'(SRC_W) << k;
  assign row_d     = (DST_ADDR_W'(linha) << k) + DST_ADDR_W'(di);
  assign col_d     = (DST_ADDR_W'(coluna) << k) + DST_ADDR_W'(dj);
  assign addr_calc = row_d * dw + col_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_FETCH;
      S_FETCH: state_nxt = S_WAIT;
      S_WAIT:  if (wait_last) state_nxt = S_WRITE;
      S_WRITE: if (blk_end) state_nxt = last_px ? S_DONE : S_FETCH;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (kill) state_nxt = S_IDLE;
  end

  always_comb begin
    ram_we   = (state == S_WRITE);
    busy     = (state != S_IDLE);
    done     = (state == S_DONE);
    ram_data = pix;
    ram_addr = ram_we ? addr_calc : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      k        <= '0;
      linha    <= '0;
      coluna   <= '0;
      di       <= '0;
      dj       <= '0;
      wcnt     <= '0;
      pix      <= '0;
      rom_addr <= '0;
    end else if (kill) begin
      linha  <= '0;
      coluna <= '0;
      di     <= '0;
      dj     <= '0;
      wcnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            k      <= (zoom == 2'd3) ? 2'd0 : zoom;
            linha  <= '0;
            coluna <= '0;
            di     <= '0;
            dj     <= '0;
            wcnt   <= '0;
          end
        end
        S_FETCH: begin
          rom_addr <= SRC_ADDR_W'(linha) * SRC_ADDR_W'(SRC_W) + SRC_ADDR_W'(coluna);
          wcnt     <= '0;
        end
        S_WAIT: begin
          wcnt <= wcnt + 1'b1;
          if (wait_last) begin
            pix <= rom_data;
            di  <= '0;
            dj  <= '0;
          end
        end
        S_WRITE: begin
          if (beat) begin
            if (dj == fmax) begin
              dj <= '0;
              if (di == fmax) begin
                di <= '0;
                if (coluna == CW'(SRC_W - 1)) begin
                  coluna <= '0;
                  linha  <= last_px ? '0 : linha + 1'b1;
                end else begin
                  coluna <= coluna + 1'b1;
                end
              end else begin
                di <= di + 1'b1;
              end
            end else begin
              dj <= dj + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef SCALE_CTRL_ABORT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) aborted <= 1'b0;
    else      aborted <= kill;
  end
`endif

endmodule

// File: tb/tb_scale_ctrl.sv
// tb/tb_scale_ctrl.sv - randomized self-checking bench for scale_ctrl against a write-list model
module tb_scale_ctrl;

  localparam int W = 6, H = 4, AW = 5, DAW = 9, LAT = 2, N = W * H;

  logic clk = 0, rst = 0, start = 0, ram_ready = 1;
  logic [1:0] zoom = 0;
  logic [AW-1:0] rom_addr, rom_q;
  logic [7:0] rom_data, ram_data;
  logic ram_we, busy, done;
  logic [DAW-1:0] ram_addr;
`ifdef SCALE_CTRL_ABORT_EN
  logic abort = 0, aborted;
`endif

  typedef struct packed {int addr; int data;} wr_t;
  wr_t expq[$];
  wr_t e_cur;
  int errors = 0, checks = 0, wr_cnt = 0, seed = 0;
  int mem_cnt[512];
  logic [7:0] mem[512];
  bit stall = 0;
  logic p_we = 0, p_rdy = 1;
  logic [DAW-1:0] p_addr = 0;
  logic [7:0] p_data = 0;

  scale_ctrl #(.SRC_W(W), .SRC_H(H), .SRC_ADDR_W(AW), .DST_ADDR_W(DAW), .ROM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .zoom(zoom), .rom_addr(rom_addr), .rom_data(rom_data),
    .ram_we(ram_we), .ram_ready(ram_ready), .ram_addr(ram_addr), .ram_data(ram_data),
    .busy(busy), .done(done)
`ifdef SCALE_CTRL_ABORT_EN
    , .abort(abort), .aborted(aborted)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input int a, input int s);
    return 8'(a * 37 + s);
  endfunction

  // Two-cycle ROM: one address register plus the combinational lookup.
  always @(posedge clk) rom_q <= rom_addr;
  assign rom_data = rom_f(int'(rom_q), seed);

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    #1 ram_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (rst) begin
      if (p_we && !p_rdy) begin
        chk("hold_we", ram_we, 1);
        chk("hold_addr", ram_addr, p_addr);
        chk("hold_data", ram_data, p_data);
      end
      if (ram_we && ram_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_write: got addr %0d expected no write", ram_addr);
        end else begin
          e_cur = expq.pop_front();
          chk("wr_addr", ram_addr, e_cur.addr);
          chk("wr_data", ram_data, e_cur.data);
        end
        wr_cnt++;
        mem_cnt[ram_addr]++;
        mem[ram_addr] = ram_data;
      end
    end
    p_we = ram_we; p_rdy = ram_ready; p_addr = ram_addr; p_data = ram_data;
  end

  // Every source pixel in raster order expands to an FxF block in the zoomed image.
  task automatic build_q(input int k);
    int f = 1 << k;
    expq.delete();
    wr_cnt = 0;
    foreach (mem_cnt[i]) mem_cnt[i] = 0;
    for (int p = 0; p < N; p++)
      for (int di = 0; di < f; di++)
        for (int dj = 0; dj < f; dj++)
          expq.push_back('{addr: ((p / W) * f + di) * (W * f) + (p % W) * f + dj, data: int'(rom_f(p, seed))});
  endtask

  task automatic run_frame(input logic [1:0] z, input bit stl, input bit poke);
    int k, f, n, bad;
    bit got;
    k = (z == 2'd3) ? 0 : int'(z);
    f = 1 << k;
    seed = $urandom_range(0, 255);
    build_q(k);
    stall = stl;
    @(negedge clk); start = 1; zoom = z;
    @(posedge clk); #1 start = 0;
    n = 0; got = 0;
    while (n < 20000 && !got) begin
      @(negedge clk);
      if (done) got = 1;
      else begin
        chk("busy_in_frame", busy, 1);
        n++;
        if (poke && n == 30) begin start = 1; zoom = z ^ 2'd1; end
        if (poke && n == 33) start = 0;
      end
    end
    chk("done_seen", got, 1);
    if (!stl) chk("frame_cycles", n, N * (1 + LAT + f * f));
    chk("write_count", wr_cnt, N * f * f);
    chk("queue_empty", expq.size(), 0);
    chk("done_busy", busy, 1);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
    chk("idle_busy", busy, 0);
    bad = 0;
    for (int a = 0; a < N * f * f; a++) if (mem_cnt[a] != 1) bad++;
    chk("written_once", bad, 0);
    stall = 0;
  endtask

  initial begin
    int g;
    repeat (3) @(negedge clk);
    chk("rst_we", ram_we, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_ram_data", ram_data, 0);
    rst = 1;
    @(negedge clk);

    run_frame(2'd0, 0, 0);
    chk("x1_pix7", mem[7], rom_f(7, seed));
    run_frame(2'd1, 0, 0);
    // Source (1,3) at x2 with W=6: rows 2..3, cols 6..7 of a 12-wide image.
    chk("x2_a30", mem[30], rom_f(9, seed));
    chk("x2_a31", mem[31], rom_f(9, seed));
    chk("x2_a42", mem[42], rom_f(9, seed));
    chk("x2_a43", mem[43], rom_f(9, seed));
    run_frame(2'd2, 0, 0);
    chk("x4_last", mem[383], rom_f(23, seed));
    chk("x4_last_once", mem_cnt[383], 1);
    run_frame(2'd3, 0, 0);
    run_frame(2'd2, 1, 0);
    run_frame(2'd1, 1, 1);
    run_frame(2'd0, 1, 1);

    seed = $urandom_range(0, 255);
    build_q(1);
    @(negedge clk); start = 1; zoom = 2'd1;
    @(posedge clk); #1 start = 0;
    g = 0;
    while (!(wr_cnt >= 20 && ram_we) && g < 1000) begin @(negedge clk); g++; end
    chk("reset_reached_write", g < 1000, 1);
    rst = 0;
    #1;
    chk("midrst_we", ram_we, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_ram_addr", ram_addr, 0);
    expq.delete();
    @(negedge clk); rst = 1;
    repeat (4) begin @(negedge clk); chk("post_rst_idle", busy, 0); chk("post_rst_done", done, 0); end

`ifdef SCALE_CTRL_ABORT_EN
    @(negedge clk); abort = 1;
    @(posedge clk); #1 chk("abort_idle_ignored", aborted, 0);
    abort = 0;
    seed = $urandom_range(0, 255);
    build_q(2);
    @(negedge clk); start = 1; zoom = 2'd2;
    @(posedge clk); #1 start = 0;
    g = 0;
    while (wr_cnt < 100 && g < 2000) begin @(negedge clk); g++; end
    chk("abort_reached", g < 2000, 1);
    abort = 1;
    @(posedge clk); #1;
    chk("aborted_pulse", aborted, 1);
    chk("abort_we", ram_we, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    abort = 0;
    expq.delete();
    @(negedge clk);
    chk("aborted_clear", aborted, 0);
    chk("abort_no_done", done, 0);
    run_frame(2'd0, 0, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
